// File: rtl/coreabc_iram_pkg.sv
// Shared IRAM constants and the init-controller state encoding.
// These defaults are also used by the IRAM and the CoreABC top.
package coreabc_iram_pkg;

    localparam int IRAM_AWIDTH     = 9;
    localparam int IRAM_DWIDTH     = 9;
    localparam int IRAM_INIT_WORDS = 512;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

endpackage

// File: rtl/coreabc_iram_wr_stage.sv
// Registered IRAM write port: an accepted beat becomes a write one cycle later.
// Latency 1 clk; no backpressure (the RAM always takes the write).
module coreabc_iram_wr_stage
    import coreabc_iram_pkg::*;
#(
    parameter int AWIDTH = IRAM_AWIDTH,
    parameter int DWIDTH = IRAM_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data,
    output logic              wenable,
    output logic [AWIDTH-1:0] initaddr,
    output logic [DWIDTH-1:0] initdata
);

    // Address and data hold their last value between writes; only WENABLE pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wenable  <= 1'b0;
            initaddr <= '0;
            initdata <= '0;
        end else begin
            wenable <= wr;
            if (wr) begin
                initaddr <= addr;
                initdata <= data;
            end
        end
    end

endmodule

// File: rtl/coreabc_iram_init_ctrl.sv
// Loads the CoreABC instruction RAM from a valid/ready stream and holds the core in reset until done.
// Write lands 1 clk after accept; READY only in LOAD/CHECK. IRAM_INIT_CHECKSUM_EN adds a trailing sum word.
module coreabc_iram_init_ctrl
    import coreabc_iram_pkg::*;
#(
    parameter int AWIDTH     = IRAM_AWIDTH,
    parameter int DWIDTH     = IRAM_DWIDTH,
    parameter int INIT_WORDS = IRAM_INIT_WORDS
) (
    input  logic              PCLK,
    input  logic              NSYSRESET,
    input  logic              INIT_START,
    input  logic              INIT_VALID,
    input  logic [DWIDTH-1:0] INIT_DATA,
    output logic              INIT_READY,
    output logic              RAM_WENABLE,
    output logic [AWIDTH-1:0] RAM_INITADDR,
    output logic [DWIDTH-1:0] RAM_INITDATA,
    output logic              CORE_HOLD,
    output logic              INIT_BUSY,
    output logic              INIT_DONE,
    output logic              INIT_ERR
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(INIT_WORDS - 1);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [AWIDTH-1:0] addr;
    logic              core_hold_q;
    logic              accept;
    logic              load_beat;
    logic              last_beat;
    logic              restart;

    assign INIT_READY = (state == ST_LOAD) || (state == ST_CHECK);
    assign accept     = INIT_READY && INIT_VALID;
    assign load_beat  = accept && (state == ST_LOAD);
    assign last_beat  = load_beat && (addr == LAST_ADDR);
    // START is only honoured outside an active load.
    assign restart    = INIT_START &&
                        ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

`ifdef IRAM_INIT_CHECKSUM_EN
    logic [DWIDTH-1:0] sum;

    always_ff @(posedge PCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            sum <= '0;
        end else if (restart) begin
            sum <= '0;
        end else if (load_beat) begin
            sum <= sum + INIT_DATA;
        end
    end

    assign INIT_ERR = (state == ST_ERR);
`else
    assign INIT_ERR = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (restart) state_nx = ST_LOAD;
            ST_LOAD: begin
                if (last_beat) begin
`ifdef IRAM_INIT_CHECKSUM_EN
                    state_nx = ST_CHECK;
`else
                    state_nx = ST_DONE;
`endif
                end
            end
`ifdef IRAM_INIT_CHECKSUM_EN
            ST_CHECK: if (accept) state_nx = (INIT_DATA == sum) ? ST_DONE : ST_ERR;
            ST_ERR:   if (restart) state_nx = ST_LOAD;
`endif
            ST_DONE: if (restart) state_nx = ST_LOAD;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state       <= ST_IDLE;
            addr        <= '0;
            core_hold_q <= 1'b1;
        end else begin
            state <= state_nx;
            // Release one cycle into DONE so the final RAM write has landed first.
            core_hold_q <= !((state == ST_DONE) && (state_nx == ST_DONE));
            if (restart) begin
                addr <= '0;
            end else if (load_beat && !last_beat) begin
                addr <= addr + AWIDTH'(1);
            end
        end
    end

    assign CORE_HOLD = core_hold_q;
    assign INIT_BUSY = (state == ST_LOAD) || (state == ST_CHECK);
    assign INIT_DONE = (state == ST_DONE);

    coreabc_iram_wr_stage #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_wr_stage (
        .clk      (PCLK),
        .rst_n    (NSYSRESET),
        .wr       (load_beat),
        .addr     (addr),
        .data     (INIT_DATA),
        .wenable  (RAM_WENABLE),
        .initaddr (RAM_INITADDR),
        .initdata (RAM_INITDATA)
    );

endmodule

// File: tb/tb_coreabc_iram_init_ctrl.sv
// Directed bench: full 512-word loads on one instance, cycle vectors on an INIT_WORDS=1 instance.
module tb_coreabc_iram_init_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       valid;
    logic [8:0] data;

    logic       ready, wen, hold, busy, done, err;
    logic [8:0] waddr, wdata;
    logic       r1_ready, r1_wen, r1_hold, r1_busy, r1_done, r1_err;
    logic [8:0] r1_addr, r1_wdata;

    logic [8:0] mem [512];
    int total = 0;
    int bad   = 0;

    localparam bit CSUM =
`ifdef IRAM_INIT_CHECKSUM_EN
        1'b1;
`else
        1'b0;
`endif

    always #5 clk = ~clk;

    coreabc_iram_init_ctrl #(.AWIDTH(9), .DWIDTH(9), .INIT_WORDS(512)) u_dut (
        .PCLK(clk), .NSYSRESET(rst_n), .INIT_START(start), .INIT_VALID(valid),
        .INIT_DATA(data), .INIT_READY(ready), .RAM_WENABLE(wen), .RAM_INITADDR(waddr),
        .RAM_INITDATA(wdata), .CORE_HOLD(hold), .INIT_BUSY(busy), .INIT_DONE(done),
        .INIT_ERR(err)
    );

    coreabc_iram_init_ctrl #(.AWIDTH(9), .DWIDTH(9), .INIT_WORDS(1)) u_dut1 (
        .PCLK(clk), .NSYSRESET(rst_n), .INIT_START(start), .INIT_VALID(valid),
        .INIT_DATA(data), .INIT_READY(r1_ready), .RAM_WENABLE(r1_wen), .RAM_INITADDR(r1_addr),
        .RAM_INITDATA(r1_wdata), .CORE_HOLD(r1_hold), .INIT_BUSY(r1_busy), .INIT_DONE(r1_done),
        .INIT_ERR(r1_err)
    );

    typedef struct {
        logic       st;
        logic       vl;
        logic [8:0] d;
        logic       rdy;
        logic       wen;
        logic [8:0] a;
        logic [8:0] wd;
        logic       hold;
        logic       busy;
        logic       done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] img(input int i, input bit allff);
        return allff ? 9'h1FF : i[8:0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_wen"},   wen,   0);
        chk({tag, "_addr"},  waddr, 0);
        chk({tag, "_data"},  wdata, 0);
        chk({tag, "_hold"},  hold,  1);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_done"},  done,  0);
        chk({tag, "_err"},   err,   0);
    endtask

    // One image load on the 512-word instance; delta skews the trailing checksum word.
    task automatic load(input int pct, input int start_at, input int rst_at,
                        input bit allff, input logic [8:0] delta);
        int         beats = 0;
        int         cyc   = 0;
        int         first = -1;
        int         errs  = 0;
        bit         acc;
        bit         aborted = 1'b0;
        bit         pulsed  = 1'b0;
        logic [8:0] w;
        logic [8:0] sum = '0;
        for (int i = 0; i < 512; i++) mem[i] = ~img(i, allff);
        @(negedge clk);
        start = 1'b1;
        valid = 1'b0;
        @(posedge clk); #1;
        chk("start_busy", busy, 1);
        chk("start_hold", hold, 1);
        chk("start_done", done, 0);
        chk("start_err",  err,  0);
        while (beats < 512 && cyc < 4000) begin
            @(negedge clk);
            start = 1'b0;
            if (start_at >= 0 && beats == start_at && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (rst_at >= 0 && beats == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals("midload_rst");
                @(posedge clk);
                @(negedge clk);
                rst_n   = 1'b1;
                start   = 1'b0;
                valid   = 1'b0;
                aborted = 1'b1;
                break;
            end
            w     = img(beats, allff);
            valid = ($urandom_range(99) < pct);
            data  = w;
            #1;
            chk("ready", ready, 1);
            acc = valid;
            @(posedge clk); #1;
            cyc++;
            chk("wen", wen, acc);
            if (acc) begin
                chk("waddr", waddr, beats);
                chk("wdata", wdata, w);
                mem[waddr] = wdata;
                sum = sum + w;
                if (first < 0) first = cyc;
                beats++;
            end
            chk("load_hold", hold, 1);
            chk("load_done", done, !CSUM && beats == 512);
        end
        if (!aborted) begin
            chk("beat_count", beats, 512);
            if (pct == 100) chk("first_write_cycle", first, 1);
`ifdef IRAM_INIT_CHECKSUM_EN
            @(negedge clk);
            start = 1'b0;
            valid = 1'b1;
            data  = sum + delta;
            #1;
            chk("check_ready", ready, 1);
            @(posedge clk); #1;
            chk("check_no_write", wen, 0);
            chk("check_done", done, delta == 0);
            chk("check_err",  err,  delta != 0);
            chk("check_busy", busy, 0);
            @(negedge clk);
            valid = 1'b0;
            @(posedge clk); #1;
            chk("check_hold", hold, delta != 0);
`else
            @(negedge clk);
            start = 1'b0;
            valid = 1'b0;
            @(posedge clk); #1;
            chk("final_hold", hold, 0);
            chk("final_done", done, 1);
            chk("final_wen",  wen,  0);
            chk("final_busy", busy, 0);
`endif
            for (int i = 0; i < 512; i++) if (mem[i] !== img(i, allff)) errs++;
            chk("ram_readback", errs, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{1'b0, 1'b1, 9'h055, 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 9'h0A5, 1'b0, 1'b1, 9'h000, 9'h0A5, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 9'h033, 1'b0, 1'b0, 9'h000, 9'h0A5, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 9'h0A5, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 9'h012, 1'b0, 1'b1, 9'h000, 9'h012, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 9'h012, 1'b0, 1'b0, 1'b1};

        do_reset();
        #1;
        chk_reset_vals("reset");
        chk("reset1_hold", r1_hold, 1);
        chk("reset1_wen",  r1_wen,  0);

`ifndef IRAM_INIT_CHECKSUM_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = tbl[i].st;
            valid = tbl[i].vl;
            data  = tbl[i].d;
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready", i), r1_ready, tbl[i].rdy);
            chk($sformatf("v%0d_wen", i),   r1_wen,   tbl[i].wen);
            chk($sformatf("v%0d_addr", i),  r1_addr,  tbl[i].a);
            chk($sformatf("v%0d_wdata", i), r1_wdata, tbl[i].wd);
            chk($sformatf("v%0d_hold", i),  r1_hold,  tbl[i].hold);
            chk($sformatf("v%0d_busy", i),  r1_busy,  tbl[i].busy);
            chk($sformatf("v%0d_done", i),  r1_done,  tbl[i].done);
            chk($sformatf("v%0d_err", i),   r1_err,   0);
        end
`else
        @(negedge clk);
        valid = 1'b1;
        data  = 9'h055;
        @(posedge clk); #1;
        chk("w1_idle_no_write", r1_wen, 0);
        @(negedge clk);
        start = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        data  = 9'h0A5;
        @(posedge clk); #1;
        chk("w1_wen",   r1_wen,   1);
        chk("w1_addr",  r1_addr,  0);
        chk("w1_wdata", r1_wdata, 9'h0A5);
        chk("w1_busy",  r1_busy,  1);
        chk("w1_done",  r1_done,  0);
        @(posedge clk); #1;
        chk("w1_check_no_write", r1_wen, 0);
        chk("w1_check_done", r1_done, 1);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk); #1;
        chk("w1_check_hold", r1_hold, 0);
`endif

        do_reset();
        load(100, -1, -1, 1'b0, 9'h000);
        load(50, -1, -1, 1'b0, 9'h000);
        load(100, 100, -1, 1'b0, 9'h000);

        // Reload from DONE: hold reasserts with LOAD and addressing restarts at 0.
        @(negedge clk);
        start = 1'b1;
        valid = 1'b0;
        @(posedge clk); #1;
        chk("reload_hold", hold, 1);
        chk("reload_busy", busy, 1);
        chk("reload_done", done, 0);
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        data  = 9'h007;
        @(posedge clk); #1;
        chk("reload_wen",  wen,   1);
        chk("reload_addr", waddr, 0);

        do_reset();
        load(100, -1, 300, 1'b0, 9'h000);
        load(100, -1, -1, 1'b0, 9'h000);

`ifdef IRAM_INIT_CHECKSUM_EN
        load(100, -1, -1, 1'b1, 9'h000);
        load(100, -1, -1, 1'b1, 9'h001);
        load(100, -1, -1, 1'b1, 9'h000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
